bcd_timer_ctrl: RTL and testbench

//   Sequencer for a chain of BCD digit counters forming a multi-digit up/down timer.

---
 rtl/bcd_timer_pkg.sv | 25 ++
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_timer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD up/down timer controller.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: synchronous load, enabled up/down step with 9<->0 wrap.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [3:0] i_data,
  input  logic       i_up,
  output logic [3:0] o_value,
  output logic       o_at_max,
  output logic       o_at_min
);

  logic [3:0] r_value;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value <= BCD_MIN;
    end else if (i_load) begin
      r_value <= i_data;
    end else if (i_en) begin
      if (i_up) r_value <= (r_value == BCD_MAX) ? BCD_MIN : r_value + 4'd1;
      else      r_value <= (r_value == BCD_MIN) ? BCD_MAX : r_value - 4'd1;
    end
  end

  assign o_value  = r_value;
  assign o_at_max = (r_value == BCD_MAX);
  assign o_at_min = (r_value == BCD_MIN);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Multi-digit BCD up/down timer: command FSM, step prescaler and digit carry chain.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 3,
  parameter int unsigned PW       = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CMD_VALID,
  input  logic [1:0]            CMD_OP,
  input  logic                  CMD_UP,
  input  logic [4*DIGITS-1:0]   CMD_DATA,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  RUNNING,
  output logic                  DONE,
  output logic                  ERR
);

  state_t              r_state, w_nxt_state;
  logic [PW-1:0]       r_presc, w_nxt_presc;
  logic                r_dir, w_nxt_dir;
  logic                r_running, r_done, r_err;
  logic                w_running_nxt, w_done_nxt, w_err_nxt;

  logic                w_load, w_step;
  logic [4*DIGITS-1:0] w_load_data;
  logic [4*DIGITS-1:0] w_count;
  logic [DIGITS-1:0]   w_at_max, w_at_min, w_en;
  logic                w_chain;
  logic                w_data_ok, w_all_max, w_all_min;
  logic                w_upper_max, w_upper_min, w_step_term;
  op_t                 w_op;

  assign w_op = op_t'(CMD_OP);

  // A step lands on terminal only from ..998/..001-style values, so decide it
  // from the current digits instead of waiting for the updated count.
  always_comb begin
    w_data_ok   = 1'b1;
    w_all_max   = 1'b1;
    w_all_min   = 1'b1;
    w_upper_max = 1'b1;
    w_upper_min = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!digit_ok(CMD_DATA[4*i +: 4])) w_data_ok = 1'b0;
      w_all_max = w_all_max & w_at_max[i];
      w_all_min = w_all_min & w_at_min[i];
      if (i > 0) begin
        w_upper_max = w_upper_max & w_at_max[i];
        w_upper_min = w_upper_min & w_at_min[i];
      end
    end
    w_step_term = r_dir ? (w_upper_max && (w_count[3:0] == BCD_MAX - 4'd1))
                        : (w_upper_min && (w_count[3:0] == BCD_MIN + 4'd1));
  end

  always_comb begin
    w_chain = w_step;
    w_en    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_en[i] = w_chain;
      w_chain = w_chain & (r_dir ? w_at_max[i] : w_at_min[i]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_en    (w_en[g]),
      .i_load  (w_load),
      .i_data  (w_load_data[4*g +: 4]),
      .i_up    (r_dir),
      .o_value (w_count[4*g +: 4]),
      .o_at_max(w_at_max[g]),
      .o_at_min(w_at_min[g])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_dir     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_presc   <= w_nxt_presc;
      r_dir     <= w_nxt_dir;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Any command owns the cycle: the prescaler and the step wait for an idle slot.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_presc = r_presc;
    w_nxt_dir   = r_dir;
    w_load      = 1'b0;
    w_load_data = '0;
    w_step      = 1'b0;
    if (CMD_VALID) begin
      case (w_op)
        OP_LOAD: begin
          if (r_state != ST_RUN && w_data_ok) begin
            w_load      = 1'b1;
            w_load_data = CMD_DATA;
            w_nxt_state = ST_IDLE;
          end
        end
        OP_START: begin
          if (r_state == ST_IDLE || r_state == ST_PAUSE) begin
            w_nxt_dir = CMD_UP;
            if (r_state == ST_IDLE) w_nxt_presc = '0;
            w_nxt_state = (CMD_UP ? w_all_max : w_all_min) ? ST_DONE : ST_RUN;
          end
        end
        OP_STOP: begin
          if (r_state == ST_RUN) w_nxt_state = ST_PAUSE;
        end
        OP_CLEAR: begin
          w_load      = 1'b1;
          w_load_data = '0;
          w_nxt_presc = '0;
          w_nxt_state = ST_IDLE;
        end
        default: ;
      endcase
    end else if (r_state == ST_RUN) begin
      if (r_presc == PW'(PRESCALE - 1)) begin
        w_nxt_presc = '0;
        w_step      = 1'b1;
        if (w_step_term) w_nxt_state = ST_DONE;
      end else begin
        w_nxt_presc = r_presc + 1'b1;
      end
    end
  end

  always_comb begin
    w_running_nxt = (w_nxt_state == ST_RUN);
    w_done_nxt    = (w_nxt_state == ST_DONE) && (r_state != ST_DONE);
    w_err_nxt     = 1'b0;
    if (CMD_VALID) begin
      case (w_op)
        OP_LOAD:  w_err_nxt = (r_state == ST_RUN) || !w_data_ok;
        OP_START: w_err_nxt = (r_state == ST_RUN) || (r_state == ST_DONE);
        default:  w_err_nxt = 1'b0;
      endcase
    end
  end

  assign COUNT   = w_count;
  assign RUNNING = r_running;
  assign DONE    = r_done;
  assign ERR     = r_err;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: decimal-arithmetic reference model, per-cycle compare, directed pins.
module tb_bcd_timer_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 3;
  localparam int unsigned PW       = 8;
  localparam int          MOD      = 10000;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FIN   = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic [1:0]  CMD_OP = 2'd0;
  logic        CMD_UP = 1'b0;
  logic [15:0] CMD_DATA = 16'h0000;
  logic [15:0] COUNT;
  logic        RUNNING, DONE, ERR;

  int checks = 0;
  int failures = 0;

  int m_val = 0;
  int m_phase = 0;
  int m_mode = M_IDLE;
  bit m_up = 1'b0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;

  bcd_timer_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PW(PW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CMD_VALID(CMD_VALID),
    .CMD_OP   (CMD_OP),
    .CMD_UP   (CMD_UP),
    .CMD_DATA (CMD_DATA),
    .COUNT    (COUNT),
    .RUNNING  (RUNNING),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic bit bcd_valid(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit at_end(input int v, input bit up);
    return up ? (v == MOD - 1) : (v == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: timer value as a plain integer, step every PRESCALE run cycles.
  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      m_val = 0; m_phase = 0; m_up = 1'b0; m_mode = M_IDLE; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (CMD_VALID) begin
        case (CMD_OP)
          2'd0: begin
            if (m_mode == M_RUN || !bcd_valid(CMD_DATA)) m_err = 1'b1;
            else begin m_val = bcd2int(CMD_DATA); m_mode = M_IDLE; end
          end
          2'd1: begin
            if (m_mode == M_RUN || m_mode == M_FIN) m_err = 1'b1;
            else begin
              if (m_mode == M_IDLE) m_phase = 0;
              m_up = CMD_UP;
              if (at_end(m_val, m_up)) begin m_mode = M_FIN; m_done = 1'b1; end
              else m_mode = M_RUN;
            end
          end
          2'd2: if (m_mode == M_RUN) m_mode = M_PAUSE;
          default: begin m_mode = M_IDLE; m_val = 0; m_phase = 0; end
        endcase
      end else if (m_mode == M_RUN) begin
        m_phase++;
        if (m_phase == PRESCALE) begin
          m_phase = 0;
          m_val = m_up ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
          if (at_end(m_val, m_up)) begin m_mode = M_FIN; m_done = 1'b1; end
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    checks++;
    if (COUNT !== int2bcd(m_val) || RUNNING !== (m_mode == M_RUN) ||
        DONE !== m_done || ERR !== m_err) begin
      failures++;
      $display("FAIL cycle at %0t: actual count=%h run=%b done=%b err=%b required count=%h run=%b done=%b err=%b",
               $time, COUNT, RUNNING, DONE, ERR, int2bcd(m_val), (m_mode == M_RUN), m_done, m_err);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cmd(input logic [1:0] op, input logic up, input logic [15:0] data);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_UP    = up;
    CMD_DATA  = data;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    CMD_OP    = 2'($urandom);
    CMD_UP    = 1'($urandom);
    CMD_DATA  = 16'($urandom);
  endtask

  task automatic reset_pulse();
    #2 RESET = 1'b1;
    #1;
    check("async_rst_count", 32'(COUNT), 32'h0);
    check("async_rst_running", 32'(RUNNING), 32'h0);
    check("async_rst_done", 32'(DONE), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    int r;
    idle(2);
    RESET = 1'b0;
    check("reset_count", 32'(COUNT), 32'h0);
    check("reset_flags", {29'd0, RUNNING, DONE, ERR}, 32'h0);

    cmd(2'd0, 1'b0, 16'h0100);
    check("load_0100", 32'(COUNT), 32'h0100);
    cmd(2'd1, 1'b0, 16'h0000);
    idle(3);
    check("first_down_step", 32'(COUNT), 32'h0099);
    idle(296);
    check("before_terminal", {COUNT, 13'd0, RUNNING, DONE, ERR}, {16'h0001, 16'h0004});
    idle(1);
    check("down_terminal", {COUNT, 13'd0, RUNNING, DONE, ERR}, {16'h0000, 16'h0002});
    idle(1);
    check("done_one_pulse", 32'(DONE), 32'h0);

    cmd(2'd0, 1'b0, 16'h0A00);
    check("bad_load", {COUNT, 13'd0, RUNNING, DONE, ERR}, {16'h0000, 16'h0001});
    cmd(2'd0, 1'b0, 16'h0050);
    cmd(2'd1, 1'b0, 16'h0000);
    idle(1);
    cmd(2'd0, 1'b0, 16'h1234);
    check("load_in_run", {COUNT, 13'd0, RUNNING, DONE, ERR}, {16'h0050, 16'h0005});
    cmd(2'd3, 1'b0, 16'h0000);

    cmd(2'd0, 1'b0, 16'h0999);
    cmd(2'd1, 1'b1, 16'h0000);
    idle(3);
    check("up_carry", 32'(COUNT), 32'h1000);
    cmd(2'd3, 1'b0, 16'h0000);
    cmd(2'd0, 1'b0, 16'h9998);
    cmd(2'd1, 1'b1, 16'h0000);
    idle(3);
    check("up_terminal", {COUNT, 13'd0, RUNNING, DONE, ERR}, {16'h9999, 16'h0002});
    cmd(2'd1, 1'b1, 16'h0000);
    check("start_in_done", 32'(ERR), 32'h1);
    cmd(2'd3, 1'b0, 16'h0000);
    check("clear_in_done", {COUNT, 13'd0, RUNNING, DONE, ERR}, 32'h0);
    cmd(2'd1, 1'b0, 16'h0000);
    check("start_at_terminal", {COUNT, 13'd0, RUNNING, DONE, ERR}, {16'h0000, 16'h0002});

    cmd(2'd3, 1'b0, 16'h0000);
    cmd(2'd0, 1'b0, 16'h0052);
    cmd(2'd1, 1'b0, 16'h0000);
    idle(6);
    check("reach_0050", 32'(COUNT), 32'h0050);
    idle(1);
    cmd(2'd2, 1'b0, 16'h0000);
    check("stop_pause", {15'd0, RUNNING, COUNT}, 32'h0050);
    idle(10);
    check("pause_hold", {15'd0, RUNNING, COUNT}, 32'h0050);
    cmd(2'd1, 1'b0, 16'h0000);
    idle(1);
    check("resume_phase_a", 32'(COUNT), 32'h0050);
    idle(1);
    check("resume_phase_b", 32'(COUNT), 32'h0049);

    cmd(2'd3, 1'b0, 16'h0000);
    cmd(2'd0, 1'b0, 16'h0020);
    cmd(2'd1, 1'b0, 16'h0000);
    idle(2);
    cmd(2'd2, 1'b0, 16'h0000);
    check("stop_on_step", {15'd0, RUNNING, COUNT}, 32'h0020);
    cmd(2'd1, 1'b0, 16'h0000);
    idle(1);
    check("step_after_resume", 32'(COUNT), 32'h0019);

    reset_pulse();

    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 140) idle(1);
      else if (r < 156) begin
        case ($urandom_range(0, 3))
          0:       d = int2bcd($urandom_range(0, 6));
          1:       d = int2bcd(MOD - 1 - $urandom_range(0, 6));
          2:       d = int2bcd($urandom_range(0, MOD - 1));
          default: d = 16'($urandom);
        endcase
        cmd(2'd0, 1'($urandom), d);
      end
      else if (r < 178) cmd(2'd1, 1'($urandom), 16'($urandom));
      else if (r < 190) cmd(2'd2, 1'($urandom), 16'($urandom));
      else if (r < 198) cmd(2'd3, 1'($urandom), 16'($urandom));
      else reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
